// File: rtl/bipartite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bipartite_pkg
// Description : Shared constants and FSM state encoding for the bipartite
//               drain router.
//               N      - default number of ports per side of the fabric
//               IDX_W  - width of a port index
//               state_e - transfer FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package bipartite_pkg;

  localparam int N     = 16;
  localparam int IDX_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_OPEN  = 3'd2,
    S_FLOW  = 3'd3,
    S_CLOSE = 3'd4
  } state_e;

endpackage : bipartite_pkg
`default_nettype wire

// File: rtl/rr_arbiter_16.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_16
// Description : Combinational round-robin selector. Returns the lowest set
//               request index at or above the pointer, wrapping at N.
// Ports       : req_i   [N]     request vector
//               ptr_i   [IDX_W] search start index
//               grant_o [IDX_W] selected index (0 when nothing is set)
//               valid_o         high when any request bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_16 #(
  parameter int N = bipartite_pkg::N
) (
  input  logic [N-1:0]                    req_i,
  input  logic [bipartite_pkg::IDX_W-1:0] ptr_i,
  output logic [bipartite_pkg::IDX_W-1:0] grant_o,
  output logic                            valid_o
);

  import bipartite_pkg::*;

  logic [IDX_W-1:0] w_grant;
  logic             w_found;

  always_comb begin
    int               sum;
    logic [IDX_W-1:0] idx;
    w_grant = '0;
    w_found = 1'b0;
    sum     = 0;
    idx     = '0;
    // Scan N positions starting at the pointer; the first hit wins.
    for (int i = 0; i < N; i++) begin
      sum = int'(ptr_i) + i;
      if (sum >= N) begin
        sum = sum - N;
      end
      idx = IDX_W'(sum);
      if (!w_found && req_i[idx]) begin
        w_found = 1'b1;
        w_grant = idx;
      end
    end
  end

  assign grant_o = w_grant;
  assign valid_o = w_found;

endmodule : rr_arbiter_16
`default_nettype wire

// File: rtl/bipartite_drain_router_16.sv
`default_nettype none
// ============================================================================
// Module      : bipartite_drain_router_16
// Description : Serves drain requests from output ports back to input ports
//               one transfer at a time: arbitrate, open both valves, wait
//               for settle, flow until done/timeout/abort, close valves,
//               acknowledge the requester.
// Ports       : clk, rst_n      clock, asynchronous active-low reset
//               drain_req [N]   per-output-port drain request (level)
//               drain_dst [N*4] target input-port index per output port
//               flow_done       transfer complete, sampled in FLOW only
//               abort           forces OPEN/FLOW to CLOSE
//               out_valve [N]   one-hot output-side valve command
//               in_valve  [N]   one-hot input-side valve command
//               ack       [N]   one-cycle pulse in the last CLOSE cycle
//               busy            high whenever the FSM is not IDLE
//               timeout_err     one-cycle pulse on FLOW timeout (visible
//                               in the first CLOSE cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module bipartite_drain_router_16 #(
  parameter int N             = bipartite_pkg::N,
  parameter int SETTLE_CYCLES = 4,
  parameter int FLOW_TIMEOUT  = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N-1:0]                    drain_req,
  input  logic [N*bipartite_pkg::IDX_W-1:0] drain_dst,
  input  logic                            flow_done,
  input  logic                            abort,
  output logic [N-1:0]                    out_valve,
  output logic [N-1:0]                    in_valve,
  output logic [N-1:0]                    ack,
  output logic                            busy,
  output logic                            timeout_err
);

  import bipartite_pkg::*;

  localparam int          SEL_W       = $clog2(N * IDX_W);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] FLOW_LAST   = 16'(FLOW_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0] src_q, src_d;
  logic [IDX_W-1:0] dst_q, dst_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]     out_valve_q, out_valve_d;
  logic [N-1:0]     in_valve_q, in_valve_d;
  logic [N-1:0]     ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [IDX_W-1:0] arb_grant;
  logic             arb_valid;
  logic [SEL_W-1:0] dst_base;

  rr_arbiter_16 #(
    .N (N)
  ) u_arb (
    .req_i   (drain_req),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .valid_o (arb_valid)
  );

  assign dst_base = SEL_W'(int'(arb_grant) * IDX_W);

  // Next-state and transfer bookkeeping. src/dst are only written in ARB,
  // so later request or destination changes cannot disturb a transfer.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rr_ptr_d  = rr_ptr_q;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|drain_req) begin
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (arb_valid) begin
          state_d  = S_OPEN;
          src_d    = arb_grant;
          dst_d    = drain_dst[dst_base +: IDX_W];
          rr_ptr_d = (arb_grant == IDX_W'(N - 1)) ? '0 : arb_grant + 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OPEN: begin
        if (abort) begin
          state_d = S_CLOSE;
        end else if (cnt_q >= SETTLE_LAST) begin
          state_d = S_FLOW;
        end
      end
      S_FLOW: begin
        // flow_done outranks both abort and a coincident timeout.
        if (flow_done) begin
          state_d = S_CLOSE;
        end else if (abort) begin
          state_d = S_CLOSE;
        end else if (cnt_q >= FLOW_LAST) begin
          state_d   = S_CLOSE;
          timeout_d = 1'b1;
        end
      end
      S_CLOSE: begin
        if (cnt_q >= SETTLE_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Counter restarts at zero on every state change and saturates.
  assign cnt_d = (state_d != state_q) ? 16'd0 :
                 (&cnt_q)             ? cnt_q : cnt_q + 16'd1;

  // Outputs are derived from the next state so that the registered values
  // line up exactly with the state they describe.
  always_comb begin
    out_valve_d = '0;
    in_valve_d  = '0;
    ack_d       = '0;
    busy_d      = (state_d != S_IDLE);
    if (state_d == S_OPEN || state_d == S_FLOW) begin
      out_valve_d[src_d] = 1'b1;
      in_valve_d[dst_d]  = 1'b1;
    end
    if (state_d == S_CLOSE && cnt_d == SETTLE_LAST) begin
      ack_d[src_d] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      rr_ptr_q    <= '0;
      out_valve_q <= '0;
      in_valve_q  <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valve_q <= out_valve_d;
      in_valve_q  <= in_valve_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign out_valve   = out_valve_q;
  assign in_valve    = in_valve_q;
  assign ack         = ack_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_q;

endmodule : bipartite_drain_router_16
`default_nettype wire

// File: tb/tb_bipartite_drain_router_16.sv
`default_nettype none
// ============================================================================
// Module      : tb_bipartite_drain_router_16
// Description : Self-checking bench for bipartite_drain_router_16. A table of
//               single-transfer vectors with hand-computed grants, valve
//               patterns and durations, plus a reset-during-FLOW sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bipartite_drain_router_16;

  localparam int          SETTLE = 4;
  localparam int          TMO    = 20;
  // drain_dst slots: 0->7, 2->9, 4->0, 9->14, 11->15, 15->5, others 0.
  localparam logic [63:0] D0     = 64'h5000_F0E0_0000_0907;
  // Same, with slot 2 changed to 3.
  localparam logic [63:0] D1     = 64'h5000_F0E0_0000_0307;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] drain_req;
  logic [63:0] drain_dst;
  logic        flow_done;
  logic        abort;
  logic [15:0] out_valve;
  logic [15:0] in_valve;
  logic [15:0] ack;
  logic        busy;
  logic        timeout_err;

  int total   = 0;
  int bad     = 0;
  int cur_row = -1;

  typedef struct {
    logic [15:0] req;
    logic        keep;      // keep request asserted after ack
    logic [63:0] dst2;      // drain_dst applied at valve cycle chg_at
    int          chg_at;
    int          flow_len;  // FLOW cycle (1-based) carrying flow_done; 0 = never
    int          abort_at;  // valve cycle carrying abort; -1 = never
    logic [15:0] e_out;
    logic [15:0] e_in;
    int          e_vcyc;    // cycles with valves open
    logic        e_to;
  } vec_t;

  vec_t tbl [10];
  vec_t post;

  bipartite_drain_router_16 #(
    .N             (16),
    .SETTLE_CYCLES (SETTLE),
    .FLOW_TIMEOUT  (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .drain_req   (drain_req),
    .drain_dst   (drain_dst),
    .flow_done   (flow_done),
    .abort       (abort),
    .out_valve   (out_valve),
    .in_valve    (in_valve),
    .ack         (ack),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL row%0d %s: got %0h want %0h", cur_row, name, act, exp);
    end
  endtask

  task automatic run_xfer(input vec_t v);
    int w;
    int k;
    int c;
    drain_req = v.req;
    drain_dst = D0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (out_valve == 16'h0 && w < 20);
    chk("grant_latency", w, 2);
    k = 0;
    while (out_valve != 16'h0 && k < 100) begin
      chk("out_valve", out_valve, v.e_out);
      chk("in_valve", in_valve, v.e_in);
      chk("busy_open", busy, 1);
      chk("ack_open", ack, 0);
      flow_done = (v.flow_len > 0) && (k == SETTLE + v.flow_len - 1);
      abort     = (k == v.abort_at);
      if (k == v.chg_at) drain_dst = v.dst2;
      @(negedge clk);
      k++;
    end
    flow_done = 1'b0;
    abort     = 1'b0;
    chk("valve_cycles", k, v.e_vcyc);
    chk("in_valve_closed", in_valve, 0);
    chk("timeout_err", timeout_err, v.e_to);
    c = 0;
    while (ack == 16'h0 && c < 10) begin
      chk("busy_close", busy, 1);
      @(negedge clk);
      c++;
    end
    chk("ack_delay", c, SETTLE - 1);
    chk("ack", ack, v.e_out);
    if (!v.keep) drain_req = 16'h0;
    @(negedge clk);
    chk("ack_pulse_end", ack, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int w;
    rst_n     = 1'b0;
    drain_req = 16'h0;
    drain_dst = D0;
    flow_done = 1'b0;
    abort     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valve", out_valve, 0);
    chk("rst_in_valve", in_valve, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    //          req       keep  dst2  chg flow abort e_out     e_in      vcyc to
    tbl[0] = '{16'h8001, 1'b1, D0,  -1,  3,  -1, 16'h0001, 16'h0080,  7, 1'b0};
    tbl[1] = '{16'h8001, 1'b1, D0,  -1,  3,  -1, 16'h8000, 16'h0020,  7, 1'b0};
    tbl[2] = '{16'h8001, 1'b0, D0,  -1,  1,  -1, 16'h0001, 16'h0080,  5, 1'b0};
    tbl[3] = '{16'h0004, 1'b0, D0,  -1, 10,  -1, 16'h0004, 16'h0200, 14, 1'b0};
    tbl[4] = '{16'h0004, 1'b0, D0,  -1,  0,  -1, 16'h0004, 16'h0200, 24, 1'b1};
    tbl[5] = '{16'h0010, 1'b0, D0,  -1,  0,   1, 16'h0010, 16'h0001,  2, 1'b0};
    tbl[6] = '{16'h0004, 1'b0, D1,   6,  8,  -1, 16'h0004, 16'h0200, 12, 1'b0};
    tbl[7] = '{16'h0A00, 1'b0, D0,  -1,  5,   8, 16'h0200, 16'h4000,  9, 1'b0};
    tbl[8] = '{16'h0A00, 1'b0, D0,  -1, 20,  -1, 16'h0800, 16'h8000, 24, 1'b0};
    tbl[9] = '{16'h0A00, 1'b0, D0,  -1,  0,   6, 16'h0200, 16'h4000,  7, 1'b0};

    for (int i = 0; i < 10; i++) begin
      cur_row = i;
      run_xfer(tbl[i]);
    end

    // Reset while in FLOW: everything drops immediately, no ack follows.
    cur_row   = 100;
    drain_req = 16'h0004;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (out_valve == 16'h0 && w < 20);
    chk("rst_seq_grant", out_valve, 16'h0004);
    repeat (6) @(negedge clk);
    chk("rst_seq_in_valve", in_valve, 16'h0200);
    rst_n     = 1'b0;
    drain_req = 16'h0;
    #1;
    chk("async_out_valve", out_valve, 0);
    chk("async_in_valve", in_valve, 0);
    chk("async_busy", busy, 0);
    chk("async_ack", ack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_ack", ack, 0);
      chk("post_rst_valve", out_valve, 0);
    end

    // Round-robin pointer was cleared by reset, so bit 0 wins over bit 15.
    cur_row = 101;
    post = '{16'h8001, 1'b0, D0, -1, 2, -1, 16'h0001, 16'h0080, 6, 1'b0};
    run_xfer(post);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bipartite_drain_router_16
`default_nettype wire
